// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//
// Purpose: bundles the host-side handshake and data bus of the bit-serial
// adder controller so that host and controller attach with one port.
//
// Parameters:
//   WIDTH  operand/result width in bits (must match the attached controller)
//
// Signals:
//   start  host -> ctrl  request a new operation (sampled only when idle)
//   a, b   host -> ctrl  operands, captured on the accepting edge
//   sub    host -> ctrl  subtract select (present only with SERIAL_ADDER_SUB_EN)
//   busy   ctrl -> host  bits are being processed
//   done   ctrl -> host  one-cycle pulse when sum/c_out become valid
//   sum    ctrl -> host  result, held until the next completion
//   c_out  ctrl -> host  carry out of the MSB, held with sum
//
// Modports: master (host side), slave (controller side).
// Build option: SERIAL_ADDER_SUB_EN adds the sub signal.
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  busy, done, sum, c_out
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose: bit-serial adder controller. A single 1-bit add cell (two
// half-adder stages plus a carry flop) is sequenced over WIDTH cycles to add
// two WIDTH-bit operands LSB-first. Latency is traded for area; a
// start/busy/done handshake issues one operation at a time.
//
// Parameters:
//   WIDTH  operand/result width in bits, legal range 1..64
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; abandons any in-flight operation
//   bus    serial_adder_ctrl_if.slave: start, a, b, [sub], busy, done,
//          sum, c_out
//
// Build option: SERIAL_ADDER_SUB_EN enables the sub input. When set on
// acceptance, B is inverted and the carry is preset to 1 so the cell
// computes a + ~b + 1; c_out is then the inverted borrow. Without the macro
// the block is add-only.
//
// Timing: start accepted at E0 (IDLE), bits processed at E1..E(WIDTH),
// DONE entered at E(WIDTH) with sum/c_out updated, IDLE again at E(WIDTH+1).
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_adder_ctrl_if.slave    bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    // Bit cell and operand-load values
    logic             p;
    logic             g1;
    logic             s;
    logic             g2;
    logic             carry_next;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_comb begin
        // Stage 1 half adder on the operand LSBs
        p          = a_sh[0] ^ b_sh[0];
        g1         = a_sh[0] & b_sh[0];
        // Stage 2 half adder folds in the carry flop
        s          = p ^ carry;
        g2         = p & carry;
        carry_next = g1 | g2;
        // New bit enters from the MSB side; the extended vector keeps the
        // slice legal when WIDTH=1.
        res_ext    = {s, res};
        res_next   = res_ext[WIDTH:1];
    end

    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = bus.sub ? ~bus.b : bus.b;
        carry_load = bus.sub;
`else
        b_load     = bus.b;
        carry_load = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_next;
                    res   <= res_next;
                    cnt   <= cnt + CW'(1);
                    // Final bit: publish the just-completed result directly
                    // so sum/c_out are valid in the same cycle as done.
                    if (cnt == LAST_BIT) begin
                        sum_q   <= res_next;
                        c_out_q <= carry_next;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Purpose: self-checking bench for serial_adder_ctrl. Drives a WIDTH=8 and a
// WIDTH=1 instance through their interfaces and compares results, latency
// and handshake behaviour against an arithmetic reference model.
// Build option: SERIAL_ADDER_SUB_EN also exercises subtraction.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W8 = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic last_sub;

    serial_adder_ctrl_if #(.WIDTH(W8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1))  bus1 ();

    serial_adder_ctrl #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {c_out, sum} as plain (WIDTH+1)-bit arithmetic
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
        logic [8:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 9'd1;
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    // Issue one operation on the 8-bit instance (DUT must be idle). Returns
    // cycles from acceptance to done and a count of handshake anomalies.
    // Leaves the bench at the negedge where done is (expected) high.
    task automatic do_op8(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_sub, output int lat, output int hs_err);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = op_a;
        bus8.b     = op_b;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = op_sub;
`endif
        last_sub   = op_sub;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = 1'($urandom);
`endif
        hs_err = 0;
        lat    = 0;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) hs_err++;
        while (lat < W8 + 4) begin
            @(negedge clk);
            lat++;
            if (bus8.busy === 1'b1 && bus8.done === 1'b1) hs_err++;
            if (bus8.done === 1'b1) break;
            if (bus8.busy !== 1'b1) hs_err++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.c_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8: got busy=%b done=%b sum=%h c_out=%b, want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.c_out);
        end
        checks++;
        if ({bus1.busy, bus1.done, bus1.sum, bus1.c_out} !== 4'd0) begin
            errors++;
            $display("FAIL reset_w1: got busy=%b done=%b sum=%b c_out=%b, want all 0",
                     bus1.busy, bus1.done, bus1.sum, bus1.c_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [7:0] ta [3] = '{8'h3C, 8'hFF, 8'hAA};
        logic [7:0] tb [3] = '{8'h05, 8'h01, 8'h55};
        logic [8:0] want   [3] = '{9'h041, 9'h100, 9'h0FF};
        int lat;
        int hs;
        for (int i = 0; i < 3; i++) begin
            do_op8(ta[i], tb[i], 1'b0, lat, hs);
            checks++;
            if (lat !== W8 || hs !== 0) begin
                errors++;
                $display("FAIL directed_timing[%0d]: latency=%0d anomalies=%0d, want latency=%0d anomalies=0",
                         i, lat, hs, W8);
            end
            checks++;
            if ({bus8.c_out, bus8.sum} !== want[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got c_out=%b sum=%h, want c_out=%b sum=%h",
                         i, bus8.c_out, bus8.sum, want[i][8], want[i][7:0]);
            end
            @(negedge clk);
            checks++;
            if (bus8.done !== 1'b0 || {bus8.c_out, bus8.sum} !== want[i]) begin
                errors++;
                $display("FAIL directed_hold[%0d]: got done=%b c_out=%b sum=%h, want done=0 c_out=%b sum=%h",
                         i, bus8.done, bus8.c_out, bus8.sum, want[i][8], want[i][7:0]);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        int hs;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [8:0] want;
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            want = model8(ra, rb, rs);
            do_op8(ra, rb, rs, lat, hs);
            checks++;
            if (lat !== W8 || hs !== 0 || {bus8.c_out, bus8.sum} !== want) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h sub=%b: got c_out=%b sum=%h lat=%0d anomalies=%0d, want c_out=%b sum=%h lat=%0d",
                         i, ra, rb, rs, bus8.c_out, bus8.sum, lat, hs, want[8], want[7:0], W8);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [7:0] ta [3] = '{8'h20, 8'h10, 8'h3C};
        logic [7:0] tb [3] = '{8'h10, 8'h20, 8'h05};
        logic       ts [3] = '{1'b1, 1'b1, 1'b0};
        logic [8:0] want [3] = '{9'h110, 9'h0F0, 9'h041};
        int lat;
        int hs;
        for (int i = 0; i < 3; i++) begin
            do_op8(ta[i], tb[i], ts[i], lat, hs);
            checks++;
            if (lat !== W8 || {bus8.c_out, bus8.sum} !== want[i]) begin
                errors++;
                $display("FAIL sub[%0d]: got c_out=%b sum=%h lat=%0d, want c_out=%b sum=%h lat=%0d",
                         i, bus8.c_out, bus8.sum, lat, want[i][8], want[i][7:0], W8);
            end
        end
    endtask
`endif

    // start held high: acceptances every WIDTH+2 cycles, operand churn
    // during RUN must not leak into the result.
    task automatic test_back_to_back;
        int ndone;
        int last_cyc;
        int gap_err;
        int val_err;
        int ovl_err;
        ndone = 0; last_cyc = -1; gap_err = 0; val_err = 0; ovl_err = 0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h01;
        bus8.b     = 8'h01;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = 1'b0;
`endif
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (bus8.busy === 1'b1 && bus8.done === 1'b1) ovl_err++;
            if (bus8.done === 1'b1) begin
                ndone++;
                if (bus8.sum !== 8'h02 || bus8.c_out !== 1'b0) val_err++;
                if (last_cyc >= 0 && cyc - last_cyc != W8 + 2) gap_err++;
                last_cyc = cyc;
                bus8.a = 8'h01;
                bus8.b = 8'h01;
            end else if (bus8.busy === 1'b1) begin
                bus8.a = 8'($urandom);
                bus8.b = 8'($urandom);
            end
        end
        bus8.start = 1'b0;
        bus8.a     = 8'h01;
        bus8.b     = 8'h01;
        repeat (W8 + 3) @(negedge clk);
        checks++;
        if (ndone !== 4 || gap_err !== 0) begin
            errors++;
            $display("FAIL b2b_cadence: got %0d done pulses, %0d bad gaps; want 4 pulses, 0 bad gaps",
                     ndone, gap_err);
        end
        checks++;
        if (val_err !== 0) begin
            errors++;
            $display("FAIL b2b_value: got %0d wrong results, want 0 (sum=02)", val_err);
        end
        checks++;
        if (ovl_err !== 0) begin
            errors++;
            $display("FAIL b2b_overlap: got %0d busy&done cycles, want 0", ovl_err);
        end
    endtask

    task automatic test_reset_midrun;
        int lat;
        int hs;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h3C;
        bus8.b     = 8'h05;
        @(negedge clk);          // after E0
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);   // after E3
        rst_n = 1'b0;            // sampled at E4
        @(negedge clk);
        checks++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.c_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_midrun: got busy=%b done=%b sum=%h c_out=%b, want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.c_out);
        end
        rst_n = 1'b1;
        repeat (W8 + 2) @(negedge clk);
        checks++;
        if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: got busy=%b done=%b after reset, want 0 0",
                     bus8.busy, bus8.done);
        end
        do_op8(8'h10, 8'h20, 1'b0, lat, hs);
        checks++;
        if (lat !== W8 || hs !== 0 || {bus8.c_out, bus8.sum} !== 9'h030) begin
            errors++;
            $display("FAIL reset_recover: got c_out=%b sum=%h lat=%0d anomalies=%0d, want c_out=0 sum=30 lat=%0d",
                     bus8.c_out, bus8.sum, lat, hs, W8);
        end
        @(negedge clk);
    endtask

    task automatic test_width1;
        logic [1:0] pair;
        logic [1:0] want;
        int lat;
        int hs;
        for (int i = 0; i < 4; i++) begin
            pair = 2'(i);
            want = {1'b0, pair[1]} + {1'b0, pair[0]};
            @(negedge clk);
            bus1.start = 1'b1;
            bus1.a     = pair[1];
            bus1.b     = pair[0];
`ifdef SERIAL_ADDER_SUB_EN
            bus1.sub   = 1'b0;
`endif
            @(negedge clk);
            bus1.start = 1'b0;
            bus1.a     = ~pair[1];
            bus1.b     = ~pair[0];
            hs  = (bus1.busy !== 1'b1 || bus1.done !== 1'b0) ? 1 : 0;
            lat = 0;
            while (lat < 5) begin
                @(negedge clk);
                lat++;
                if (bus1.done === 1'b1) break;
            end
            checks++;
            if (lat !== 1 || hs !== 0 || bus1.busy !== 1'b0 || {bus1.c_out, bus1.sum} !== want) begin
                errors++;
                $display("FAIL width1[a=%b b=%b]: got c_out=%b sum=%b lat=%0d busy=%b, want c_out=%b sum=%b lat=1 busy=0",
                         pair[1], pair[0], bus1.c_out, bus1.sum, lat, bus1.busy, want[1], want[0]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        last_sub   = 1'b0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = 1'b0;
        bus1.sub   = 1'b0;
`endif
        test_reset();
        test_directed();
        test_random();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        test_reset_midrun();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
